// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS core: stall/flush control,
// store-data refresh from WB while stalled, and a registered misalignment flag.
module ex_mem_pipe_reg #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rt_idx,
  input  logic [4:0]  ex_dst_idx,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_sign,
  input  logic [1:0]  ex_wb_src,
  input  logic        wb_we,
  input  logic [4:0]  wb_idx,
  input  logic [31:0] wb_data,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu_res,
  output logic [31:0] mem_rt_data,
  output logic [4:0]  mem_rt_idx,
  output logic [4:0]  mem_dst_idx,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [1:0]  mem_mem_size,
  output logic        mem_mem_sign,
  output logic [1:0]  mem_wb_src,
  output logic        mem_align_err
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] rt_data;
    logic [4:0]  rt_idx;
    logic [4:0]  dst_idx;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [1:0]  wb_src;
    logic        align_err;
  } stage_t;

  stage_t stage_q, stage_d, bubble, load;
  logic   misaligned, align_err, rt_refresh;

  always_comb begin
    case (ex_mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ex_alu_res[0];
      2'b10:   misaligned = |ex_alu_res[1:0];
      default: misaligned = 1'b1;
    endcase
    align_err = ALIGN_CHECK && ex_valid && (ex_mem_read || ex_mem_write) && misaligned;
  end

  // Store data whose producer is now in WB must be picked up before it retires.
  assign rt_refresh = stage_q.valid && stage_q.mem_write && wb_we &&
                      (wb_idx == stage_q.rt_idx) && (wb_idx != 5'd0);

  always_comb begin
    bubble    = '0;
    bubble.pc = RESET_PC;

    load.valid     = ex_valid;
    load.pc        = ex_pc;
    load.alu_res   = ex_alu_res;
    load.rt_data   = ex_rt_data;
    load.rt_idx    = ex_rt_idx;
    load.dst_idx   = ex_dst_idx;
    load.reg_write = ex_valid && ex_reg_write && (ex_dst_idx != 5'd0) && !align_err;
    load.mem_read  = ex_valid && ex_mem_read && !align_err;
    load.mem_write = ex_valid && ex_mem_write && !align_err;
    load.mem_size  = ex_mem_size;
    load.mem_sign  = ex_mem_sign;
    load.wb_src    = ex_wb_src;
    load.align_err = align_err;

    stage_d = stage_q;
    if (flush) begin
      stage_d = bubble;
    end else if (stall) begin
      if (rt_refresh) stage_d.rt_data = wb_data;
    end else begin
      stage_d = load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= '0;
      stage_q.pc <= RESET_PC;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign mem_valid     = stage_q.valid;
  assign mem_pc        = stage_q.pc;
  assign mem_alu_res   = stage_q.alu_res;
  assign mem_rt_data   = stage_q.rt_data;
  assign mem_rt_idx    = stage_q.rt_idx;
  assign mem_dst_idx   = stage_q.dst_idx;
  assign mem_reg_write = stage_q.reg_write;
  assign mem_mem_read  = stage_q.mem_read;
  assign mem_mem_write = stage_q.mem_write;
  assign mem_mem_size  = stage_q.mem_size;
  assign mem_mem_sign  = stage_q.mem_sign;
  assign mem_wb_src    = stage_q.wb_src;
  assign mem_align_err = stage_q.align_err;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg; a second instance with ALIGN_CHECK=0
// shares the inputs to cover the disabled alignment check.
module tb_ex_mem_pipe_reg;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_sign;
  logic [31:0] ex_pc, ex_alu_res, ex_rt_data;
  logic [4:0]  ex_rt_idx, ex_dst_idx;
  logic [1:0]  ex_mem_size, ex_wb_src;
  logic        wb_we;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_sign;
  logic        mem_align_err;
  logic [31:0] mem_pc, mem_alu_res, mem_rt_data;
  logic [4:0]  mem_rt_idx, mem_dst_idx;
  logic [1:0]  mem_mem_size, mem_wb_src;

  logic        n_valid, n_reg_write, n_mem_read, n_mem_write, n_mem_sign, n_align_err;
  logic [31:0] n_pc, n_alu_res, n_rt_data;
  logic [4:0]  n_rt_idx, n_dst_idx;
  logic [1:0]  n_mem_size, n_wb_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.RESET_PC(RPC), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_res(ex_alu_res), .ex_rt_data(ex_rt_data),
    .ex_rt_idx(ex_rt_idx), .ex_dst_idx(ex_dst_idx), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_sign(ex_mem_sign), .ex_wb_src(ex_wb_src),
    .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_res(mem_alu_res),
    .mem_rt_data(mem_rt_data), .mem_rt_idx(mem_rt_idx), .mem_dst_idx(mem_dst_idx),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_size(mem_mem_size),
    .mem_mem_sign(mem_mem_sign), .mem_wb_src(mem_wb_src), .mem_align_err(mem_align_err)
  );

  ex_mem_pipe_reg #(.RESET_PC(RPC), .ALIGN_CHECK(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_res(ex_alu_res), .ex_rt_data(ex_rt_data),
    .ex_rt_idx(ex_rt_idx), .ex_dst_idx(ex_dst_idx), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_sign(ex_mem_sign), .ex_wb_src(ex_wb_src),
    .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .mem_valid(n_valid), .mem_pc(n_pc), .mem_alu_res(n_alu_res),
    .mem_rt_data(n_rt_data), .mem_rt_idx(n_rt_idx), .mem_dst_idx(n_dst_idx),
    .mem_reg_write(n_reg_write), .mem_mem_read(n_mem_read),
    .mem_mem_write(n_mem_write), .mem_mem_size(n_mem_size),
    .mem_mem_sign(n_mem_sign), .mem_wb_src(n_wb_src), .mem_align_err(n_align_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    stall = 0; flush = 0;
    ex_valid = 0; ex_pc = 0; ex_alu_res = 0; ex_rt_data = 0; ex_rt_idx = 0; ex_dst_idx = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 2'b10;
    ex_mem_sign = 0; ex_wb_src = 0; wb_we = 0; wb_idx = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    clear_ex();
    ex_valid = 1; ex_pc = 32'h40; ex_alu_res = 32'h200; ex_rt_data = 32'h55;
    ex_rt_idx = 5'd3; ex_dst_idx = 5'd4; ex_reg_write = 1; ex_mem_read = 1; ex_wb_src = 2'b01;
    step();
    #3 rst = 1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_pc !== RPC || mem_alu_res !== 32'h0 ||
        mem_rt_data !== 32'h0 || mem_dst_idx !== 5'd0 || mem_reg_write !== 1'b0 ||
        mem_mem_read !== 1'b0 || mem_wb_src !== 2'b00 || mem_align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b pc=%h alu=%h rd=%b actual, want 0 pc=%h",
               mem_valid, mem_pc, mem_alu_res, mem_mem_read, RPC);
    end
    @(posedge clk);
    #1 rst = 0;
    clear_ex();
    ex_valid = 1; ex_alu_res = 32'h100;
    step();
    checks++;
    if (mem_alu_res !== 32'h100 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: alu=%h valid=%b, want 100 1", mem_alu_res, mem_valid);
    end
  endtask

  task automatic test_load_bubble();
    clear_ex();
    ex_valid = 1; ex_reg_write = 1; ex_dst_idx = 5'd0;
    step();
    checks++;
    if (mem_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rw_dst0: reg_write=%b want 0", mem_reg_write);
    end
    ex_dst_idx = 5'd7; ex_pc = 32'h1234; ex_mem_sign = 1; ex_wb_src = 2'b10;
    step();
    checks++;
    if (mem_reg_write !== 1'b1 || mem_dst_idx !== 5'd7 || mem_pc !== 32'h1234 ||
        mem_mem_sign !== 1'b1 || mem_wb_src !== 2'b10) begin
      errors++;
      $display("FAIL rw_dst7: rw=%b dst=%0d pc=%h sign=%b src=%b want 1 7 1234 1 10",
               mem_reg_write, mem_dst_idx, mem_pc, mem_mem_sign, mem_wb_src);
    end
    clear_ex();
    ex_valid = 0; ex_mem_write = 1; ex_reg_write = 1; ex_dst_idx = 5'd9;
    ex_alu_res = 32'hDEAD_BEE0;
    step();
    checks++;
    if (mem_mem_write !== 1'b0 || mem_valid !== 1'b0 || mem_reg_write !== 1'b0 ||
        mem_alu_res !== 32'hDEAD_BEE0) begin
      errors++;
      $display("FAIL bubble_in: wr=%b valid=%b rw=%b alu=%h want 0 0 0 deadbee0",
               mem_mem_write, mem_valid, mem_reg_write, mem_alu_res);
    end
  endtask

  task automatic load_sw(input logic [4:0] rt, input logic [31:0] pc);
    clear_ex();
    ex_valid = 1; ex_mem_write = 1; ex_mem_size = 2'b10; ex_alu_res = 32'h2000;
    ex_rt_idx = rt; ex_rt_data = 32'h1111; ex_pc = pc;
    step();
    ex_pc = 32'hFFFF_FFF0; ex_alu_res = 32'h0; ex_rt_data = 32'h9999; ex_mem_write = 0;
    stall = 1;
    step();
  endtask

  task automatic test_stall_refresh();
    load_sw(5'd8, 32'h400);
    checks++;
    if (mem_rt_data !== 32'h1111 || mem_pc !== 32'h400 || mem_mem_write !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: rt=%h pc=%h wr=%b want 1111 400 1",
               mem_rt_data, mem_pc, mem_mem_write);
    end
    wb_we = 1; wb_idx = 5'd8; wb_data = 32'hABCD;
    step();
    checks++;
    if (mem_rt_data !== 32'hABCD || mem_pc !== 32'h400 || mem_alu_res !== 32'h2000 ||
        mem_mem_write !== 1'b1 || mem_rt_idx !== 5'd8 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rt_refresh: rt=%h pc=%h alu=%h wr=%b want abcd 400 2000 1",
               mem_rt_data, mem_pc, mem_alu_res, mem_mem_write);
    end
    load_sw(5'd8, 32'h500);
    wb_we = 1; wb_idx = 5'd9; wb_data = 32'hABCD;
    step();
    checks++;
    if (mem_rt_data !== 32'h1111) begin
      errors++;
      $display("FAIL refresh_idx9: rt=%h want 1111", mem_rt_data);
    end
    load_sw(5'd0, 32'h600);
    wb_we = 1; wb_idx = 5'd0; wb_data = 32'hABCD;
    step();
    checks++;
    if (mem_rt_data !== 32'h1111) begin
      errors++;
      $display("FAIL refresh_idx0: rt=%h want 1111", mem_rt_data);
    end
  endtask

  task automatic test_flush_stall();
    clear_ex();
    ex_valid = 1; ex_mem_read = 1; ex_mem_size = 2'b10; ex_alu_res = 32'h3000;
    ex_pc = 32'h80; ex_reg_write = 1; ex_dst_idx = 5'd2;
    step();
    stall = 1; flush = 1;
    step();
    checks++;
    if (mem_valid !== 1'b0 || mem_mem_read !== 1'b0 || mem_pc !== RPC ||
        mem_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: valid=%b rd=%b pc=%h want 0 0 %h",
               mem_valid, mem_mem_read, mem_pc, RPC);
    end
    stall = 0; flush = 0;
    step();
    stall = 1;
    #2 rst = 1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_pc !== RPC || mem_alu_res !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%b pc=%h alu=%h want 0 %h 0",
               mem_valid, mem_pc, mem_alu_res, RPC);
    end
    step();
    rst = 0;
  endtask

  task automatic test_alignment();
    clear_ex();
    ex_valid = 1; ex_mem_read = 1; ex_mem_size = 2'b01; ex_alu_res = 32'h1001;
    ex_reg_write = 1; ex_dst_idx = 5'd5;
    step();
    checks++;
    if (mem_align_err !== 1'b1 || mem_mem_read !== 1'b0 || mem_valid !== 1'b1 ||
        mem_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL lh_1001: err=%b rd=%b valid=%b rw=%b want 1 0 1 0",
               mem_align_err, mem_mem_read, mem_valid, mem_reg_write);
    end
    checks++;
    if (n_align_err !== 1'b0 || n_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL nochk_lh_1001: err=%b rd=%b want 0 1", n_align_err, n_mem_read);
    end
    stall = 1;
    step();
    checks++;
    if (mem_align_err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: err=%b want 1", mem_align_err);
    end
    clear_ex();
    ex_valid = 1; ex_mem_write = 1; ex_mem_size = 2'b10; ex_alu_res = 32'h1002;
    step();
    checks++;
    if (mem_align_err !== 1'b1 || mem_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL sw_1002: err=%b wr=%b want 1 0", mem_align_err, mem_mem_write);
    end
    ex_alu_res = 32'h1004;
    step();
    checks++;
    if (mem_align_err !== 1'b0 || mem_mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sw_1004: err=%b wr=%b want 0 1", mem_align_err, mem_mem_write);
    end
    ex_mem_write = 0; ex_mem_read = 1; ex_mem_size = 2'b11; ex_alu_res = 32'h1000;
    step();
    checks++;
    if (mem_align_err !== 1'b1 || mem_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL size11: err=%b rd=%b want 1 0", mem_align_err, mem_mem_read);
    end
    ex_mem_size = 2'b00; ex_alu_res = 32'h1003;
    step();
    checks++;
    if (mem_align_err !== 1'b0 || mem_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL lb_1003: err=%b rd=%b want 0 1", mem_align_err, mem_mem_read);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0000_1000; pcs[1] = 32'h0000_1004;
    pcs[2] = 32'h0000_1008; pcs[3] = 32'h0000_100C;
    clear_ex();
    ex_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ex_pc = pcs[i];
      if (i > 0) begin
        checks++;
        if (mem_pc !== pcs[i-1]) begin
          errors++;
          $display("FAIL b2b_pre%0d: pc=%h want %h", i, mem_pc, pcs[i-1]);
        end
      end
      step();
      checks++;
      if (mem_pc !== pcs[i] || mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: pc=%h valid=%b want %h 1", i, mem_pc, mem_valid, pcs[i]);
      end
    end
  endtask

  initial begin
    rst = 1;
    clear_ex();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_load_bubble();
    test_stall_refresh();
    test_flush_stall();
    test_alignment();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
